// File: rtl/fused_pack_arbiter.sv
// Arbitrates NUM_REQ requesters and packs BEATS consecutive words from the winner into one wide burst.
// Define FUSED_PACK_FIXED_PRIO_EN for fixed-priority arbitration (lowest index wins); default is round-robin.
module fused_pack_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int BEATS   = 4,
    localparam int SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W*BEATS-1:0]   out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SRC_W-1:0]          out_src,
    output logic                      busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, OUTPUT = 2'd2} state_t;

    state_t                  state_q;
    logic [SRC_W-1:0]        grant_q;
    logic [SRC_W-1:0]        out_src_q;
    logic [CNT_W-1:0]        beat_cnt_q;
    logic [DATA_W*BEATS-1:0] out_data_q;
    logic                    out_valid_q;
    logic                    busy_q;
    logic [SRC_W-1:0]        start_s;
    logic [SRC_W-1:0]        winner_s;
    logic                    last_beat_s;
`ifndef FUSED_PACK_FIXED_PRIO_EN
    logic [SRC_W-1:0]        rr_ptr_q;
`endif

    // Arbitration search origin: the round-robin pointer, or index 0 for fixed priority
    always_comb begin
`ifdef FUSED_PACK_FIXED_PRIO_EN
        start_s = '0;
`else
        start_s = rr_ptr_q;
`endif
    end

    // Ascending search from start_s with wrap; first valid requester wins
    always_comb begin
        logic [SRC_W:0] idx_v;
        logic           found_v;
        idx_v    = '0;
        found_v  = 1'b0;
        winner_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_v = {1'b0, start_s} + (SRC_W+1)'(i);
            if (idx_v >= (SRC_W+1)'(NUM_REQ)) begin
                idx_v = idx_v - (SRC_W+1)'(NUM_REQ);
            end else begin
                idx_v = idx_v;
            end
            if (!found_v && req_valid[idx_v[SRC_W-1:0]]) begin
                winner_s = idx_v[SRC_W-1:0];
                found_v  = 1'b1;
            end else begin
                found_v  = found_v;
            end
        end
    end

    // Only the granted requester may hand over a beat, and only while collecting
    always_comb begin
        req_ready = '0;
        if (state_q == COLLECT) begin
            req_ready[grant_q] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    assign last_beat_s = (beat_cnt_q == CNT_W'(BEATS - 1));

    // Burst FSM: arbitrate, collect BEATS words from one owner, hold the burst until accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            out_src_q   <= '0;
            beat_cnt_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifndef FUSED_PACK_FIXED_PRIO_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        grant_q    <= winner_s;
                        out_src_q  <= winner_s;
                        beat_cnt_q <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= COLLECT;
                    end else begin
                        state_q    <= IDLE;
                    end
                end
                COLLECT: begin
                    // A missing word from the owner is a bubble: nothing moves
                    if (req_valid[grant_q]) begin
                        out_data_q[beat_cnt_q*DATA_W +: DATA_W] <= req_data[grant_q*DATA_W +: DATA_W];
                        if (last_beat_s) begin
                            beat_cnt_q  <= '0;
                            out_valid_q <= 1'b1;
                            state_q     <= OUTPUT;
                        end else begin
                            beat_cnt_q  <= beat_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        beat_cnt_q <= beat_cnt_q;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
`ifndef FUSED_PACK_FIXED_PRIO_EN
                        rr_ptr_q    <= (grant_q == SRC_W'(NUM_REQ - 1)) ? '0 : grant_q + SRC_W'(1);
`endif
                    end else begin
                        state_q     <= OUTPUT;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_src   = out_src_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fused_pack_arbiter.sv
// Directed bench for fused_pack_arbiter: table of single-owner bursts plus hand-written
// contention and reset-abort sequences.
module tb_fused_pack_arbiter;
    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic [127:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_src;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string            name;
        int               src;
        logic [3:0][31:0] w;
        int               bub_after;
        int               bub_len;
        int               hold;
        logic [127:0]     exp_data;
        int               exp_lat;
    } vec_t;

    vec_t vecs[5];

    fused_pack_arbiter #(.NUM_REQ(4), .DATA_W(32), .BEATS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src   (out_src),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 4'b0000;
        req_data  = 128'd0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] rw(input int i, input int c);
        rw = {8'hC0 + 8'(i), 16'h5A5A, 8'(c)};
    endfunction

    // Latency counts the cycle in which req_valid is first presented as cycle 1.
    task automatic run_burst(input vec_t v);
        int   k;
        int   bub;
        int   lat;
        logic acc;
        logic seen;
        k    = 0;
        bub  = 0;
        lat  = 1;
        seen = 1'b0;
        out_ready = (v.hold == 0);
        req_valid = 4'b0000;
        req_valid[v.src] = 1'b1;
        req_data  = {4{32'hDEAD_BEEF}};
        req_data[v.src*32 +: 32] = v.w[0];
        for (int c = 0; c < 60 && !seen; c++) begin
            acc = req_ready[v.src] & req_valid[v.src];
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (acc) k++;
            if (out_valid) begin
                seen = 1'b1;
            end else if (k == v.bub_after && bub < v.bub_len) begin
                req_valid[v.src] = 1'b0;
                bub++;
                chk({v.name, "_bubble_ready"}, 128'(req_ready), 128'(4'b0001 << v.src));
            end else if (k < 4) begin
                req_valid[v.src] = 1'b1;
                req_data[v.src*32 +: 32] = v.w[k];
            end
        end
        if (!seen) begin
            chk({v.name, "_timeout"}, 128'(0), 128'(1));
            req_valid = 4'b0000;
            return;
        end
        chk({v.name, "_data"}, out_data, v.exp_data);
        chk({v.name, "_src"}, 128'(out_src), 128'(v.src));
        chk({v.name, "_latency"}, 128'(lat), 128'(v.exp_lat));
        chk({v.name, "_ready_out"}, 128'(req_ready), 128'(0));
        // Other requesters contend while the burst waits; no one may be granted
        req_valid = 4'b1111;
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            chk({v.name, "_hold_data"}, out_data, v.exp_data);
            chk({v.name, "_hold_src"}, 128'(out_src), 128'(v.src));
            chk({v.name, "_hold_valid"}, 128'(out_valid), 128'(1));
            chk({v.name, "_hold_ready"}, 128'(req_ready), 128'(0));
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'b0000;
        chk({v.name, "_valid_drop"}, 128'(out_valid), 128'(0));
        chk({v.name, "_retain"}, out_data, v.exp_data);
        chk({v.name, "_idle"}, 128'(busy), 128'(0));
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int         cnt[4];
        int         nb;
        int         per_src[4];
        int         exp_src[5];
        int         e;
        int         n;
        int         k;
        logic [3:0] acc;
        vec_t       v;

        vecs[0] = '{"single_src1", 1, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
                    0, 0, 0, 128'h44444444_33333333_22222222_11111111, 6};
        vecs[1] = '{"bubble_src2", 2, {32'hA4A4A4A4, 32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1},
                    2, 3, 0, 128'hA4A4A4A4_A3A3A3A3_A2A2A2A2_A1A1A1A1, 9};
        vecs[2] = '{"stall_src3", 3, {32'h0BAD_F00D, 32'hCAFE_BABE, 32'h1234_5678, 32'h8765_4321},
                    0, 0, 5, 128'h0BADF00D_CAFEBABE_12345678_87654321, 6};
        vecs[3] = '{"pattern_src0", 0, {32'h76543210, 32'hFEDCBA98, 32'h89ABCDEF, 32'h01234567},
                    0, 0, 0, 128'h76543210_FEDCBA98_89ABCDEF_01234567, 6};
        vecs[4] = '{"mixed_src1", 1, {32'hFFFFFFFF, 32'h00000000, 32'h80000001, 32'h7FFFFFFE},
                    1, 1, 2, 128'hFFFFFFFF_00000000_80000001_7FFFFFFE, 7};

        do_reset();
        chk("rst_out_data", out_data, 128'd0);
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_src", 128'(out_src), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_req_ready", 128'(req_ready), 128'(0));

        for (int i = 0; i < 5; i++) begin
            run_burst(vecs[i]);
        end

        // All four requesters stream continuously; each owns whole bursts
`ifdef FUSED_PACK_FIXED_PRIO_EN
        exp_src = '{0, 0, 0, 0, 0};
`else
        exp_src = '{0, 1, 2, 3, 0};
`endif
        do_reset();
        cnt     = '{0, 0, 0, 0};
        per_src = '{0, 0, 0, 0};
        nb        = 0;
        out_ready = 1'b1;
        req_valid = 4'b1111;
        for (int c = 0; c < 200 && nb < 5; c++) begin
            for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = rw(i, cnt[i]);
            acc = req_ready & req_valid;
            @(posedge clk);
            @(negedge clk);
            for (int i = 0; i < 4; i++) if (acc[i]) cnt[i]++;
            if (out_valid) begin
                e = exp_src[nb];
                n = per_src[e];
                chk($sformatf("rr_src_%0d", nb), 128'(out_src), 128'(e));
                chk($sformatf("rr_data_%0d", nb), out_data,
                    {rw(e, 4*n+3), rw(e, 4*n+2), rw(e, 4*n+1), rw(e, 4*n)});
                per_src[e]++;
                nb++;
            end
        end
        if (nb < 5) chk("rr_timeout", 128'(nb), 128'(5));
        req_valid = 4'b0000;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset after three beats of a burst discards it
        do_reset();
        out_ready = 1'b1;
        req_valid = 4'b1000;
        k = 0;
        for (int c = 0; c < 20 && k < 3; c++) begin
            req_data[3*32 +: 32] = 32'h3000_0000 + 32'(k);
            acc = req_ready & req_valid;
            @(posedge clk);
            @(negedge clk);
            if (acc[3]) k++;
        end
        chk("abort_beats", 128'(k), 128'(3));
        reset     = 1'b1;
        req_valid = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("abort_valid", 128'(out_valid), 128'(0));
        chk("abort_data", out_data, 128'd0);
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_ready", 128'(req_ready), 128'(0));
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("abort_no_valid", 128'(out_valid), 128'(0));
        v = '{"after_abort_src3", 3, {32'hD4D4D4D4, 32'hD3D3D3D3, 32'hD2D2D2D2, 32'hD1D1D1D1},
              0, 0, 0, 128'hD4D4D4D4_D3D3D3D3_D2D2D2D2_D1D1D1D1, 6};
        run_burst(v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fused_pack_arbiter.md
FUSED_PACK_ARBITER -- requirements
Module: fused_pack_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of 32-bit requesters sharing the packer.
REQ-002 SHALL have parameter DATA_W, default 32, requester word width.
REQ-003 SHALL have parameter BEATS, default 4, words per packed output; out width = DATA_W*BEATS (128).
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester word valid.
REQ-007 SHALL have port req_data  input  NUM_REQ*DATA_W  requester i word at [i*DATA_W +: DATA_W].
REQ-008 SHALL have port req_ready  output  NUM_REQ  per-requester word accept.
REQ-009 SHALL have port out_data  output  DATA_W*BEATS  packed burst.
REQ-010 SHALL have port out_valid  output  1  packed burst valid.
REQ-011 SHALL have port out_ready  input  1  downstream accept.
REQ-012 SHALL have port out_src  output  $clog2(NUM_REQ)  index of requester owning out_data.
REQ-013 SHALL have port busy  output  1  high whenever state != IDLE.

Function
REQ-014 SHALL implement a registered FSM with states IDLE, COLLECT, OUTPUT.
REQ-015 IDLE: req_ready all 0; if any req_valid high, SHALL register the winner in grant, set out_src = grant, clear beat_cnt, go COLLECT next cycle.
REQ-016 IDLE with no req_valid SHALL remain in IDLE.
REQ-017 Default arbitration SHALL be round-robin: search starts at rr_ptr, ascending, wrapping at NUM_REQ-1 -> 0.
REQ-018 COLLECT: req_ready[grant] = 1 combinationally, all other req_ready bits 0.
REQ-019 A beat is accepted when req_valid[grant] & req_ready[grant]; beat k SHALL be written to out_data[k*DATA_W +: DATA_W] (beat 0 in [31:0]).
REQ-020 beat_cnt ($clog2(BEATS) bits) SHALL increment per accepted beat; cycles without req_valid[grant] SHALL be bubbles with grant held and no data change.
REQ-021 The accepted beat with beat_cnt == BEATS-1 SHALL move the FSM to OUTPUT and set out_valid = 1 the next cycle.
REQ-022 OUTPUT: out_data, out_src, out_valid SHALL hold stable until out_ready; req_ready all 0.
REQ-023 OUTPUT with out_ready = 1: out_valid SHALL be 0 next cycle, rr_ptr <= (grant+1) mod NUM_REQ, state -> IDLE.
REQ-024 Bursts SHALL never interleave: one requester owns the packer from grant to output handshake.
REQ-025 Minimum latency SHALL be 6 cycles from req_valid sampled in IDLE to out_valid (1 arbitration + 4 beats + 1 register); throughput at most one burst per BEATS+2 cycles.
REQ-026 out_data SHALL retain its last value after handshake until overwritten by the next burst.

Reset
REQ-027 On reset: state = IDLE, out_data = 0, out_valid = 0, out_src = 0, grant = 0, beat_cnt = 0, rr_ptr = 0, busy = 0, req_ready = 0.
REQ-028 Reset in COLLECT or OUTPUT SHALL discard the partial/pending burst; no out_valid for it follows.

Configuration
REQ-029 Macro FUSED_PACK_FIXED_PRIO_EN defined: arbitration SHALL be fixed-priority, lowest index wins; rr_ptr absent/unused.
REQ-030 Macro FUSED_PACK_FIXED_PRIO_EN undefined: round-robin per REQ-017/REQ-023.

Verification
REQ-031 Single requester 1 sends 0x11111111,0x22222222,0x33333333,0x44444444 back-to-back, out_ready=1 -> out_data=0x44444444_33333333_22222222_11111111, out_src=1, out_valid 6 cycles after first req_valid.
REQ-032 All 4 requesters valid continuously, round-robin -> out_src sequence 0,1,2,3,0; no mixed words within any burst.
REQ-033 Same as REQ-032 with FUSED_PACK_FIXED_PRIO_EN -> out_src always 0.
REQ-034 Requester 2 drops req_valid for 3 cycles after beat 1 -> grant held, req_ready[2] stays 1, packed data correct, out_valid 3 cycles later than nominal.
REQ-035 out_ready held 0 for 5 cycles in OUTPUT -> out_data/out_src stable, req_ready all 0, new grant only after handshake.
REQ-036 Reset asserted after beat 2 -> out_valid 0, out_data 0, state IDLE; next burst packs from beat 0 correctly.
